board_led_scanner: RTL and testbench
====================================

// Module: board_led_scanner
// PURPOSE
//  Display stage downstream of the connect4 game core. Takes the 4x4 occupancy map (gameboard)
//  and owner map (player_moves) and time-multiplexes them onto one shared 8-bit LED data bus
//  plus 4 one-hot column enables, replacing four static 8-bit column ports.
//  Blinks cells flagged in a highlight mask, e.g. the winning line from DetectWinner.
//  Board is snapshotted once per frame so a move landing mid-scan never tears the display.
// PARAMETERS
//  DWELL_CYCLES  1000  clk cycles each column is driven (>=1)
//  ENABLE_GAP    2     blanking cycles before each column, anti-ghosting (>=1)
//  BLINK_FRAMES  32    frames per blink half-period (>=1)
// PORTS
//  clk           in   1   system clock; all logic on rising edge
//  reset         in   1   synchronous, active-low reset
//  gameboard     in   16  cell occupied flags; column c = bits [4c+3:4c], row k = bit 4c+k
//  player_moves  in   16  cell owner, 0=player0, 1=player1 (ignored where gameboard=0)
//  highlight     in   16  cells to blink, same indexing
//  blink_en      in   1   1=apply blinking to highlighted cells
//  col_data      out  8   LED data for active column; row k drives bits [2k+1:2k]
//  col_sel       out  4   one-hot column enable, bit c = column c; 0 while blanking
//  frame_start   out  1   1-cycle pulse on first cycle of each frame
//  blink_phase   out  1   current blink half-period (1 = highlighted cells dark)
// BEHAVIOUR
//  - Reset (reset=0 at edge): state=BLANK, col=0, dwell/gap/frame counters=0, snapshots=0;
//    col_data=0, col_sel=0, frame_start=0, blink_phase=0. Overrides everything, any state.
//  - All outputs registered, updated on the same edge as state; no extra latency.
//  - FSM: BLANK (ENABLE_GAP cycles, col_sel=0, col_data=0) -> DRIVE (DWELL_CYCLES cycles,
//    col_sel=1<<col, col_data=encoded column) -> BLANK of col+1. col wraps 3->0.
//    Frame = 4*(ENABLE_GAP+DWELL_CYCLES) cycles.
//  - First edge with reset=1 enters BLANK col0 = frame start: frame_start=1 that cycle.
//    The same holds on every wrap to BLANK col0.
//  - Snapshot: gameboard/player_moves/highlight sampled into internal registers on each
//    frame-start edge only. Mid-frame input changes become visible next frame.
//  - Cell encoding, per row k: empty -> 00; owner0 -> 01; owner1 -> 10; never 11.
//  - Blink: frame counter increments at each frame start. On reaching BLINK_FRAMES it
//    clears and toggles blink_phase, so each half-period is BLINK_FRAMES frames.
//    If blink_en=1 and blink_phase=1, highlighted cells encode 00.
//    blink_en=0 shows all cells steadily; blink_phase keeps toggling regardless.
//  - blink_en is sampled live each cycle (not snapshotted).
//  - Counter widths: $clog2 of their max value, min 1 bit. No overflow beyond terminal
//    counts.
// TESTING  (DWELL_CYCLES=4, ENABLE_GAP=1, BLINK_FRAMES=2; frame=20 cycles)
//  1 Reset: reset=0 for 3 edges -> col_data=0, col_sel=0, frame_start=0, blink_phase=0.
//  2 Scan: gameboard=16'h0001, player_moves=0 -> per frame col_sel = 0,1x4, 0,2x4, 0,4x4, 0,8x4;
//    col_data=8'h01 only during col0 drive; frame_start every 20 cycles.
//  3 Encode: gameboard=16'hFFFF, player_moves=16'hA5A5 -> col0 data 8'h66, col1 8'h99,
//    col2 8'h66, col3 8'h99.
//  4 Snapshot: set gameboard 0->16'hFFFF during col1 drive -> col_data stays 0 for the rest of
//    the frame; from next frame_start col0=8'h55.
//  5 Blink: gameboard=highlight=16'h0001, blink_en=1 -> col0 data 8'h01 for 2 frames, then 8'h00
//    for 2 frames, repeating. blink_en=0 -> steady 8'h01 while blink_phase still toggles.
//  6 Mid-op reset: reset=0 during col2 drive -> next edge all outputs 0; on release,
//    frame_start=1 and scan restarts at col0.

Source files
------------

// File: rtl/board_led_scanner_if.sv
// Purpose: bundles the board-state inputs and LED scan outputs of board_led_scanner.
//   gameboard/player_moves/highlight (16) : 4x4 occupancy, owner and blink maps
//   blink_en (1)                          : apply blinking to highlighted cells
//   col_data (8), col_sel (4)             : shared LED data bus and one-hot column enable
//   frame_start (1), blink_phase (1)      : frame pulse and current blink half-period
// master = board source / LED consumer, slave = the scanner.
interface board_led_scanner_if;
    logic [15:0] gameboard;
    logic [15:0] player_moves;
    logic [15:0] highlight;
    logic        blink_en;
    logic [7:0]  col_data;
    logic [3:0]  col_sel;
    logic        frame_start;
    logic        blink_phase;

    modport master (
        output gameboard, player_moves, highlight, blink_en,
        input  col_data, col_sel, frame_start, blink_phase
    );

    modport slave (
        input  gameboard, player_moves, highlight, blink_en,
        output col_data, col_sel, frame_start, blink_phase
    );
endinterface

// File: rtl/board_led_scanner.sv
// Purpose: time-multiplexes a 4x4 connect4 board onto one 8-bit LED bus with one-hot
// column enables, blanking between columns and blinking highlighted cells.
//   clk    : system clock, rising edge
//   reset  : synchronous active-low reset
//   bus    : board_led_scanner_if.slave (board maps in, scan outputs out, all registered)
module board_led_scanner #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned ENABLE_GAP   = 2,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    board_led_scanner_if.slave    bus
);

    localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned GAP_W   = (ENABLE_GAP > 1)   ? $clog2(ENABLE_GAP)   : 1;
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(ENABLE_GAP - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    typedef enum logic {S_BLANK, S_DRIVE} state_e;

    state_e              state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                started_q, started_d;
    logic [15:0]         snap_occ_q, snap_occ_d;
    logic [15:0]         snap_own_q, snap_own_d;
    logic [15:0]         snap_hl_q, snap_hl_d;
    logic [7:0]          col_data_q, col_data_d;
    logic [3:0]          col_sel_q, col_sel_d;
    logic                frame_start_q, frame_start_d;
    logic                blink_phase_q, blink_phase_d;
    logic                frame_edge;

    // Two LED bits per row: empty 00, owner0 01, owner1 10; blanked cells go dark.
    function automatic logic [7:0] encode_col(input logic [3:0] occ, input logic [3:0] own,
                                              input logic [3:0] hl, input logic dark);
        logic [7:0] enc;
        enc = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (occ[k] && !(dark && hl[k])) begin
                enc[2*k +: 2] = own[k] ? 2'b10 : 2'b01;
            end
        end
        return enc;
    endfunction

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_BLANK;
            col_q         <= 2'd0;
            dwell_q       <= '0;
            gap_q         <= '0;
            frame_q       <= '0;
            started_q     <= 1'b0;
            snap_occ_q    <= 16'h0000;
            snap_own_q    <= 16'h0000;
            snap_hl_q     <= 16'h0000;
            col_data_q    <= 8'h00;
            col_sel_q     <= 4'h0;
            frame_start_q <= 1'b0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            dwell_q       <= dwell_d;
            gap_q         <= gap_d;
            frame_q       <= frame_d;
            started_q     <= started_d;
            snap_occ_q    <= snap_occ_d;
            snap_own_q    <= snap_own_d;
            snap_hl_q     <= snap_hl_d;
            col_data_q    <= col_data_d;
            col_sel_q     <= col_sel_d;
            frame_start_q <= frame_start_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Next-state, snapshot, blink and registered-output computation.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        dwell_d       = dwell_q;
        gap_d         = gap_q;
        frame_d       = frame_q;
        started_d     = 1'b1;
        snap_occ_d    = snap_occ_q;
        snap_own_d    = snap_own_q;
        snap_hl_d     = snap_hl_q;
        blink_phase_d = blink_phase_q;
        frame_start_d = 1'b0;
        col_sel_d     = 4'h0;
        col_data_d    = 8'h00;
        frame_edge    = 1'b0;

        if (!started_q) begin
            // First edge out of reset enters BLANK col0 as a frame start.
            state_d    = S_BLANK;
            col_d      = 2'd0;
            gap_d      = '0;
            frame_edge = 1'b1;
        end else begin
            case (state_q)
                S_BLANK: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_DRIVE;
                        dwell_d = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (dwell_q == DWELL_LAST) begin
                        state_d    = S_BLANK;
                        gap_d      = '0;
                        col_d      = col_q + 2'd1;
                        frame_edge = (col_q == 2'd3);
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
                default: state_d = S_BLANK;
            endcase
        end

        // Board is captured only at frame start so a mid-scan move cannot tear the display.
        if (frame_edge) begin
            frame_start_d = 1'b1;
            snap_occ_d    = bus.gameboard;
            snap_own_d    = bus.player_moves;
            snap_hl_d     = bus.highlight;
            if (frame_q == FRAME_LAST) begin
                frame_d       = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end

        // Snapshot and phase never change on a DRIVE-entry edge, so the _q copies are current.
        if (state_d == S_DRIVE) begin
            col_sel_d  = 4'b0001 << col_d;
            col_data_d = encode_col(snap_occ_q[{col_d, 2'b00} +: 4],
                                    snap_own_q[{col_d, 2'b00} +: 4],
                                    snap_hl_q[{col_d, 2'b00} +: 4],
                                    bus.blink_en && blink_phase_q);
        end
    end

    assign bus.col_data    = col_data_q;
    assign bus.col_sel     = col_sel_q;
    assign bus.frame_start = frame_start_q;
    assign bus.blink_phase = blink_phase_q;

endmodule

// File: tb/tb_board_led_scanner.sv
// Purpose: directed self-checking bench for board_led_scanner (dwell 4, gap 1, blink 2 frames).
module tb_board_led_scanner;

    localparam int unsigned DW    = 4;
    localparam int unsigned GAP   = 1;
    localparam int unsigned BF    = 2;
    localparam int unsigned SLOT  = GAP + DW;
    localparam int unsigned FRAME = 4 * SLOT;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   t      = 0;

    always #5 clk = ~clk;

    board_led_scanner_if bus ();

    board_led_scanner #(
        .DWELL_CYCLES (DW),
        .ENABLE_GAP   (GAP),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    // t counts cycles from the first edge after reset release (t=0 is the frame-start cycle).
    // Frame-start number fr = t/FRAME+1; blink phase toggles on every BF-th frame start.
    task automatic scan(input int n, input logic [3:0][7:0] lit, input logic [3:0][7:0] dark);
        int         p, seg, off, fr;
        logic       ph;
        logic [3:0] es;
        logic [7:0] ed;
        for (int i = 0; i < n; i++) begin
            tick();
            p   = t % FRAME;
            seg = p / SLOT;
            off = p % SLOT;
            fr  = t / FRAME + 1;
            ph  = ((fr / BF) % 2) == 1;
            es  = 4'h0;
            ed  = 8'h00;
            if (off >= GAP) begin
                es = 4'(1 << seg);
                ed = (bus.blink_en && ph) ? dark[seg] : lit[seg];
            end
            check_eq("col_sel", 32'(bus.col_sel), 32'(es));
            check_eq("col_data", 32'(bus.col_data), 32'(ed));
            check_eq("frame_start", 32'(bus.frame_start), 32'(p == 0));
            check_eq("blink_phase", 32'(bus.blink_phase), 32'(ph));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_col_data"}, 32'(bus.col_data), 32'h0);
        check_eq({tag, "_col_sel"}, 32'(bus.col_sel), 32'h0);
        check_eq({tag, "_frame_start"}, 32'(bus.frame_start), 32'h0);
        check_eq({tag, "_blink_phase"}, 32'(bus.blink_phase), 32'h0);
    endtask

    initial begin
        reset            = 1'b0;
        bus.gameboard    = 16'h0001;
        bus.player_moves = 16'h0000;
        bus.highlight    = 16'h0000;
        bus.blink_en     = 1'b0;

        // Reset held for three edges.
        repeat (3) tick();
        check_zero_outputs("reset");

        // Scan order and single-cell data, two frames.
        reset = 1'b1;
        t     = -1;
        scan(2 * FRAME, {8'h00, 8'h00, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h01});

        // Full board, mixed owners.
        bus.gameboard    = 16'hFFFF;
        bus.player_moves = 16'hA5A5;
        scan(FRAME, {8'h99, 8'h66, 8'h99, 8'h66}, {8'h99, 8'h66, 8'h99, 8'h66});

        // Empty board, then fill it during col1 drive: no tearing until next frame.
        bus.gameboard    = 16'h0000;
        bus.player_moves = 16'h0000;
        scan(FRAME, 32'h0, 32'h0);
        scan(7, 32'h0, 32'h0);
        bus.gameboard = 16'hFFFF;
        scan(FRAME - 7, 32'h0, 32'h0);
        scan(FRAME, {8'h55, 8'h55, 8'h55, 8'h55}, {8'h55, 8'h55, 8'h55, 8'h55});

        // Blinking a highlighted cell, then steady with blink disabled.
        bus.gameboard = 16'h0001;
        bus.highlight = 16'h0001;
        bus.blink_en  = 1'b1;
        scan(4 * FRAME, {8'h00, 8'h00, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h00});
        bus.blink_en = 1'b0;
        scan(2 * FRAME, {8'h00, 8'h00, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h00});

        // Reset asserted during col2 drive, then scan restarts from col0.
        scan(12, {8'h00, 8'h00, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h00});
        check_eq("pre_reset_col_sel", 32'(bus.col_sel), 32'h4);
        reset = 1'b0;
        tick();
        check_zero_outputs("midreset");
        tick();
        reset = 1'b1;
        t     = -1;
        scan(FRAME, {8'h00, 8'h00, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
